// File: rtl/jesd_tx_link.sv
`default_nettype none
// ============================================================================
// Module      : jesd_tx_link
// Description : JESD204B-style single-lane transmit link layer (F=2, 4 octets
//               per clock). Sequences CGS -> WAIT -> ILAS -> DATA, keeps a
//               sysref-aligned LMFC and produces the ILAS multiframes.
// Revision    : 1.0 - initial release
// ============================================================================
module jesd_tx_link #(
    parameter int K = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sysref,
    input  logic         sync_n,
    input  logic [111:0] cfg_data,
    input  logic [31:0]  tx_data,
    output logic         tx_ready,
    output logic [31:0]  lane_data,
    output logic [3:0]   lane_charisk,
    output logic         lmfc_edge,
    output logic [1:0]   link_state
);

    localparam int         c_MF_CYCLES       = K / 2;
    localparam logic [3:0] c_LMFC_LAST       = 4'(c_MF_CYCLES - 1);
    localparam logic [5:0] c_ILAS_LAST_OCTET = 6'(2 * K - 1);

    localparam logic [1:0] c_ST_CGS  = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ILAS = 2'd2;
    localparam logic [1:0] c_ST_DATA = 2'd3;

    localparam logic [7:0] c_CHAR_K = 8'hBC;
    localparam logic [7:0] c_CHAR_R = 8'h1C;
    localparam logic [7:0] c_CHAR_A = 8'h7C;
    localparam logic [7:0] c_CHAR_Q = 8'h9C;

    logic [1:0]  r_state, w_state_nxt;
    logic [3:0]  r_lmfc, w_lmfc_nxt;
    logic [3:0]  r_ilas_cyc, w_ilas_cyc_nxt;
    logic [1:0]  r_ilas_mf, w_ilas_mf_nxt;
    logic        r_sysref_d;
    logic        r_sync_low_d;
    logic        w_sysref_edge;
    logic        w_ilas_last;
    logic [31:0] w_lane_nxt;
    logic [3:0]  w_charisk_nxt;

    logic [31:0] r_lane_data;
    logic [3:0]  r_lane_charisk;
    logic        r_tx_ready;
    logic        r_lmfc_edge;

    // One ILAS octet {is_k, value}: index within the multiframe, plus whether
    // this is the configuration-carrying multiframe.
    function automatic logic [8:0] f_ilas_octet(input logic [5:0]   idx,
                                                input logic         is_mf1,
                                                input logic [111:0] cfg);
        logic [8:0] v_oct;
        v_oct = {3'b000, idx};
        if (idx == 6'd0) begin
            v_oct = {1'b1, c_CHAR_R};
        end else if (idx == c_ILAS_LAST_OCTET) begin
            v_oct = {1'b1, c_CHAR_A};
        end else if (is_mf1) begin
            if (idx == 6'd1) begin
                v_oct = {1'b1, c_CHAR_Q};
            end
            for (int n = 0; n < 14; n++) begin
                if (idx == 6'(n + 2)) begin
                    v_oct = {1'b0, cfg[8*n +: 8]};
                end
            end
        end
        return v_oct;
    endfunction

    assign w_sysref_edge = sysref & ~r_sysref_d;
    assign w_ilas_last   = (r_ilas_cyc == c_LMFC_LAST) && (r_ilas_mf == 2'd3);

    // LMFC free-runs over one multiframe; a sysref rising edge restarts it.
    always_comb begin
        w_lmfc_nxt = r_lmfc + 4'd1;
        if (w_sysref_edge || (r_lmfc == c_LMFC_LAST)) begin
            w_lmfc_nxt = 4'd0;
        end
    end

    // Link state transitions; ILAS entry uses the upcoming LMFC value so ILAS
    // starts in the very cycle the LMFC reads 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CGS: begin
                if (sync_n) w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (!sync_n)                 w_state_nxt = c_ST_CGS;
                else if (w_lmfc_nxt == 4'd0) w_state_nxt = c_ST_ILAS;
            end
            c_ST_ILAS: begin
                if (!sync_n)          w_state_nxt = c_ST_CGS;
                else if (w_ilas_last) w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (!sync_n && r_sync_low_d) w_state_nxt = c_ST_CGS;
            end
            default: w_state_nxt = c_ST_CGS;
        endcase
    end

    // ILAS position (cycle within multiframe, multiframe number), independent
    // of the LMFC so a mid-ILAS sysref does not disturb the sequence.
    always_comb begin
        w_ilas_cyc_nxt = 4'd0;
        w_ilas_mf_nxt  = 2'd0;
        if ((w_state_nxt == c_ST_ILAS) && (r_state == c_ST_ILAS)) begin
            if (r_ilas_cyc == c_LMFC_LAST) begin
                w_ilas_mf_nxt = r_ilas_mf + 2'd1;
            end else begin
                w_ilas_cyc_nxt = r_ilas_cyc + 4'd1;
                w_ilas_mf_nxt  = r_ilas_mf;
            end
        end
    end

    // Lane octets for the upcoming cycle, selected by the upcoming state.
    always_comb begin
        w_lane_nxt    = {4{c_CHAR_K}};
        w_charisk_nxt = 4'hF;
        case (w_state_nxt)
            c_ST_ILAS: begin
                for (int b = 0; b < 4; b++) begin
                    {w_charisk_nxt[b], w_lane_nxt[8*b +: 8]} =
                        f_ilas_octet({w_ilas_cyc_nxt, 2'(b)}, (w_ilas_mf_nxt == 2'd1), cfg_data);
                end
            end
            c_ST_DATA: begin
                w_lane_nxt    = tx_data;
                w_charisk_nxt = 4'h0;
            end
            default: begin
                w_lane_nxt    = {4{c_CHAR_K}};
                w_charisk_nxt = 4'hF;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_CGS;
            r_lmfc         <= 4'd0;
            r_ilas_cyc     <= 4'd0;
            r_ilas_mf      <= 2'd0;
            r_sysref_d     <= 1'b0;
            r_sync_low_d   <= 1'b0;
            r_lane_data    <= {4{c_CHAR_K}};
            r_lane_charisk <= 4'hF;
            r_tx_ready     <= 1'b0;
            r_lmfc_edge    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_lmfc         <= w_lmfc_nxt;
            r_ilas_cyc     <= w_ilas_cyc_nxt;
            r_ilas_mf      <= w_ilas_mf_nxt;
            r_sysref_d     <= sysref;
            r_sync_low_d   <= ~sync_n;
            r_lane_data    <= w_lane_nxt;
            r_lane_charisk <= w_charisk_nxt;
            r_tx_ready     <= (w_state_nxt == c_ST_DATA);
            r_lmfc_edge    <= (w_lmfc_nxt == 4'd0);
        end
    end

    assign tx_ready     = r_tx_ready;
    assign lane_data    = r_lane_data;
    assign lane_charisk = r_lane_charisk;
    assign lmfc_edge    = r_lmfc_edge;
    assign link_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jesd_tx_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_jesd_tx_link
// Description : Scoreboard bench for jesd_tx_link. A reference model predicts
//               each cycle's outputs into a queue; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd_tx_link;

    localparam int K  = 32;
    localparam int MF = K / 2;

    localparam int M_CGS  = 0;
    localparam int M_WAIT = 1;
    localparam int M_ILAS = 2;
    localparam int M_DATA = 3;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         sysref   = 1'b0;
    logic         sync_n   = 1'b0;
    logic [111:0] cfg_data = '0;
    logic [31:0]  tx_data  = '0;
    logic         tx_ready;
    logic [31:0]  lane_data;
    logic [3:0]   lane_charisk;
    logic         lmfc_edge;
    logic [1:0]   link_state;

    jesd_tx_link #(.K(K)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sysref       (sysref),
        .sync_n       (sync_n),
        .cfg_data     (cfg_data),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .lane_data    (lane_data),
        .lane_charisk (lane_charisk),
        .lmfc_edge    (lmfc_edge),
        .link_state   (link_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lane;
        logic [3:0]  isk;
        logic        rdy;
        logic        lmfc_e;
        logic [1:0]  st;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: plain integers in terms of the link rules.
    int   m_state = M_CGS;
    int   m_lmfc  = 0;
    int   m_pos   = 0;
    bit   m_sysref_prev = 1'b0;
    bit   m_sync_prev_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.lane = 32'hBCBCBCBC;
        e.isk = 4'hF;
        e.rdy = 1'b0;
        e.lmfc_e = 1'b0;
        e.st = 2'd0;
        return e;
    endfunction

    // ILAS octet b of ILAS cycle pos (0..2K-1): {is_k, value}.
    function automatic logic [8:0] exp_ilas(input int pos, input int b);
        int mf;
        int i;
        logic [8:0] v;
        mf = pos / MF;
        i  = (pos % MF) * 4 + b;
        v  = {1'b0, 8'(i % 256)};
        if (i == 0)                            v = {1'b1, 8'h1C};
        else if (i == 2 * K - 1)               v = {1'b1, 8'h7C};
        else if (mf == 1 && i == 1)            v = {1'b1, 8'h9C};
        else if (mf == 1 && i >= 2 && i <= 15) v = {1'b0, cfg_data[(i-2)*8 +: 8]};
        return v;
    endfunction

    // Reference model: predicts the outputs of the coming cycle from the
    // inputs sampled at this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_CGS;
            m_lmfc = 0;
            m_pos = 0;
            m_sysref_prev = 1'b0;
            m_sync_prev_low = 1'b0;
            q.delete();
        end else begin
            int sn;
            int ln;
            int pn;
            exp_t e;
            ln = (sysref && !m_sysref_prev) ? 0 : (m_lmfc + 1) % MF;
            sn = m_state;
            if (m_state == M_CGS) begin
                if (sync_n) sn = M_WAIT;
            end else if (m_state == M_WAIT) begin
                if (!sync_n)      sn = M_CGS;
                else if (ln == 0) sn = M_ILAS;
            end else if (m_state == M_ILAS) begin
                if (!sync_n)               sn = M_CGS;
                else if (m_pos == 2*K - 1) sn = M_DATA;
            end else begin
                if (!sync_n && m_sync_prev_low) sn = M_CGS;
            end
            pn = (sn == M_ILAS && m_state == M_ILAS) ? m_pos + 1 : 0;
            e = reset_exp();
            e.st = 2'(sn);
            e.lmfc_e = (ln == 0);
            e.rdy = (sn == M_DATA);
            if (sn == M_ILAS) begin
                for (int b = 0; b < 4; b++) begin
                    logic [8:0] o;
                    o = exp_ilas(pn, b);
                    e.lane[8*b +: 8] = o[7:0];
                    e.isk[b] = o[8];
                end
            end else if (sn == M_DATA) begin
                e.lane = tx_data;
                e.isk = 4'h0;
            end
            q.push_back(e);
            m_state = sn;
            m_lmfc = ln;
            m_pos = pn;
            m_sysref_prev = sysref;
            m_sync_prev_low = !sync_n;
        end
    end

    // Monitor: compares outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || q.size() == 0) e = reset_exp();
        else e = q.pop_front();
        chk("lane_data", lane_data, e.lane);
        chk("lane_charisk", 32'(lane_charisk), 32'(e.isk));
        chk("tx_ready", 32'(tx_ready), 32'(e.rdy));
        chk("lmfc_edge", 32'(lmfc_edge), 32'(e.lmfc_e));
        chk("link_state", 32'(link_state), 32'(e.st));
    end

    logic [31:0] ramp = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int st, input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            sync_n = 1'b1;
            sysref = 1'b0;
            tx_data = ramp;
            ramp = ramp + 32'd1;
            if (m_state == st) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout(name);
    endtask

    // Asserts reset between edges and checks the outputs react immediately.
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk({name, "_lane"}, lane_data, 32'hBCBCBCBC);
        chk({name, "_isk"}, 32'(lane_charisk), 32'hF);
        chk({name, "_rdy"}, 32'(tx_ready), 32'h0);
        chk({name, "_lmfc"}, 32'(lmfc_edge), 32'h0);
        chk({name, "_state"}, 32'(link_state), 32'h0);
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int low_left;
        bit found;
        for (int i = 0; i < 14; i++) cfg_data[8*i +: 8] = 8'($urandom);

        // Held in reset with sync_n low: monitor sees reset values throughout.
        rst_n = 1'b0;
        sync_n = 1'b0;
        repeat (20) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // sysref pulse, then sync release, through ILAS into DATA with a ramp.
        for (int c = 0; c < 120; c++) begin
            tick();
            sysref = (c == 5);
            sync_n = (c >= 9);
            tx_data = ramp;
            ramp = ramp + 32'd1;
        end

        // Single-cycle sync_n low in DATA is ignored.
        tick(); sync_n = 1'b0; tx_data = ramp; ramp = ramp + 32'd1;
        for (int c = 0; c < 10; c++) begin
            tick(); sync_n = 1'b1; tx_data = ramp; ramp = ramp + 32'd1;
        end
        // Two-cycle sync_n low drops back to CGS.
        for (int c = 0; c < 2; c++) begin
            tick(); sync_n = 1'b0; tx_data = ramp; ramp = ramp + 32'd1;
        end
        for (int c = 0; c < 3; c++) begin
            tick(); tx_data = ramp; ramp = ramp + 32'd1;
        end

        // Abort ILAS at its cycle 30, then release for a fresh ILAS.
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            sync_n = 1'b1;
            tx_data = ramp;
            ramp = ramp + 32'd1;
            if (m_state == M_ILAS && m_pos == 30) begin
                sync_n = 1'b0;
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("ilas_cycle30");
        tick();
        wait_state(M_DATA, "reach_data_after_abort");
        repeat (5) tick();

        // Random traffic: random payload, sysref pulses, short sync_n drops.
        low_left = 0;
        for (int c = 0; c < 900; c++) begin
            tick();
            tx_data = $urandom;
            sysref = ($urandom_range(0, 19) == 0);
            if (low_left > 0) begin
                sync_n = 1'b0;
                low_left--;
            end else begin
                sync_n = 1'b1;
                if ($urandom_range(0, 149) == 0) low_left = $urandom_range(1, 3);
            end
        end

        // Asynchronous reset during DATA and during ILAS, each followed by a
        // full restart of the link sequence.
        wait_state(M_DATA, "reach_data_pre_reset");
        async_reset("rst_in_data");
        wait_state(M_ILAS, "reach_ilas_pre_reset");
        repeat (10) tick();
        async_reset("rst_in_ilas");
        wait_state(M_DATA, "reach_data_post_reset");
        repeat (10) tick();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/jesd_tx_link.md
JESD_TX_LINK -- requirements
Module: jesd_tx_link

Interface
REQ-001 The block SHALL have parameter K, default 32, giving frames per multiframe; legal values are even numbers from 10 to 32.
REQ-002 The frame size SHALL be fixed at F=2 octets, one lane, 4 octets per clock, so one multiframe (MF) is K/2 cycles.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: link/character clock (lane rate / 40).
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port sysref, input, 1 bit: synchronous to clk; its rising edge realigns the LMFC.
REQ-007 Port sync_n, input, 1 bit: synchronous to clk; low requests CGS, high releases it.
REQ-008 Port cfg_data, input, 112 bits: 14 ILAS config octets; octet n is bits [8n+7:8n].
REQ-009 Port tx_data, input, 32 bits: transport payload; octet 0 in [7:0] is transmitted first.
REQ-010 Port tx_ready, output, 1 bit: high when tx_data is consumed this cycle.
REQ-011 Port lane_data, output, 32 bits: octets to the 8b10b encoder.
REQ-012 Port lane_charisk, output, 4 bits: per-octet K-character flag.
REQ-013 Port lmfc_edge, output, 1 bit: single-cycle pulse when the LMFC counter is 0.
REQ-014 Port link_state, output, 2 bits: 0=CGS, 1=WAIT, 2=ILAS, 3=DATA.

Function
REQ-015 The LMFC counter SHALL count 0..K/2-1 and wrap; a sysref 0->1 edge (sysref high, previous-cycle sample low) SHALL force the counter to 0 in the next cycle.
REQ-016 In CGS, all octets SHALL be /K/=0xBC with charisk=4'hF.
REQ-017 CGS->WAIT SHALL occur when sync_n is sampled high.
REQ-018 In WAIT, the block SHALL keep sending /K/ and SHALL enter ILAS on the cycle where the LMFC counter is 0.
REQ-019 If sync_n goes low in WAIT, the state SHALL return to CGS.
REQ-020 ILAS SHALL last exactly 4 MFs (2K cycles), aligned to the LMFC.
REQ-021 In every ILAS MF, MF octet i SHALL default to i mod 256 (D-char).
REQ-022 In every ILAS MF, octet 0 SHALL be /R/=0x1C (K), and the last octet (2K-1) SHALL be /A/=0x7C (K).
REQ-023 In ILAS MF1 only, octet 1 SHALL be /Q/=0x9C (K), and octets 2..15 SHALL be cfg_data octets 0..13.
REQ-024 ILAS->DATA SHALL occur after the last ILAS cycle; no gap is allowed.
REQ-025 In DATA, tx_ready SHALL be 1 and lane_data SHALL equal tx_data registered one cycle earlier, with charisk=0; there is no scrambling and no character replacement.
REQ-026 tx_ready SHALL be registered-combinational from state: high in the same cycle the state is DATA.
REQ-027 Latency from tx_data accepted to lane_data SHALL be 1 clk.
REQ-028 sync_n sampled low in ILAS SHALL cause CGS next cycle, with /K/ output from that cycle.
REQ-029 In DATA, sync_n low for 2 consecutive cycles (4 frames) SHALL cause CGS; a single-cycle low SHALL be ignored.
REQ-030 A sysref edge during ILAS or DATA SHALL realign the LMFC only; the state SHALL be unaffected and the ILAS cycle count SHALL continue.
REQ-031 Simultaneous sync_n low and LMFC=0 in WAIT: the block SHALL go to CGS.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While rst_n=0, the block SHALL be in state CGS, with LMFC counter 0, lane_data=32'hBCBCBCBC, lane_charisk=4'hF, tx_ready=0, lmfc_edge=0, link_state=0.
REQ-034 After rst_n deassertion, the block SHALL start from CGS regardless of sync_n and SHALL sample sync_n from the first clk edge.
REQ-035 Reset asserted mid-ILAS or mid-DATA SHALL force the reset values immediately (asynchronously).

Verification
REQ-036 Reset with sync_n=0 for 20 cycles -> lane_data=BCBCBCBC, charisk=F, link_state=0 throughout.
REQ-037 K=32, sysref pulse at cycle 5, sync_n raised at cycle 9 -> WAIT until LMFC=0 (cycle 22); ILAS runs 64 cycles; MF1 cycle 0 lane_data=cfg1,cfg0,9C,1C with charisk=4'b0011; last cycle of each MF has octet3=7C with charisk=4'b1000; DATA starts at cycle 86.
REQ-038 In DATA, tx_data ramp 0,1,2.. -> lane_data shows the same ramp 1 cycle later, charisk=0, tx_ready=1.
REQ-039 In DATA, a single-cycle sync_n low -> data continues; two-cycle sync_n low -> /K/ from the next cycle and link_state=0.
REQ-040 sync_n low at ILAS cycle 30 -> CGS next cycle; re-release -> fresh 4-MF ILAS aligned to the next LMFC=0.
REQ-041 rst_n pulsed low in DATA -> outputs equal the REQ-033 values within the same cycle, and the CGS/ILAS sequence restarts.
